// File: rtl/pipeline_foreground_transform.sv
// Foreground placement stage: maps screen pixels to foreground-source coordinates through a
// power-of-two downscale, window offset and optional mirror, with frame-boundary shadowed control.
module pipeline_foreground_transform #(
  parameter int RESOLUTION_X = 640,
  parameter int RESOLUTION_Y = 480,
  parameter int COORD_W      = 10,
  parameter int SCALE_W      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               ctrl_fg_enable,
  input  logic [SCALE_W-1:0] ctrl_fg_scale,
  input  logic               ctrl_fg_mirror_x,
  input  logic [COORD_W-1:0] fg_offset_x,
  input  logic [COORD_W-1:0] fg_offset_y,
  output logic               out_valid,
  output logic [COORD_W-1:0] fg_pixel_x,
  output logic [COORD_W-1:0] fg_pixel_y,
  output logic               fg_active
);

  localparam logic [COORD_W-1:0] RES_X_C = COORD_W'(RESOLUTION_X);
  localparam logic [COORD_W-1:0] RES_Y_C = COORD_W'(RESOLUTION_Y);

  // Shadowed configuration
  logic               en_q, en_d;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic               mirror_q, mirror_d;
  logic [COORD_W-1:0] off_x_q, off_x_d;
  logic [COORD_W-1:0] off_y_q, off_y_d;

  // Stage 1
  logic               s1_valid_q, s1_valid_d;
  logic [COORD_W-1:0] s1_dx_q, s1_dx_d;
  logic [COORD_W-1:0] s1_dy_q, s1_dy_d;
  logic               s1_in_win_q, s1_in_win_d;
  logic               s1_en_q, s1_en_d;
  logic [SCALE_W-1:0] s1_scale_q, s1_scale_d;
  logic               s1_mirror_q, s1_mirror_d;

  // Stage 2
  logic               out_valid_q, out_valid_d;
  logic               fg_active_q, fg_active_d;
  logic [COORD_W-1:0] fg_x_q, fg_x_d;
  logic [COORD_W-1:0] fg_y_q, fg_y_d;

  logic               frame_start;
  logic [COORD_W-1:0] win_w, win_h;
  logic [COORD_W:0]   end_x, end_y;
  logic [COORD_W-1:0] s2_win_w, s2_src_x;

  assign frame_start = in_valid && (pixel_x == '0) && (pixel_y == '0);

  // Shadow capture and stage 1; the frame-start pixel itself sees the freshly captured values.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    en_d     = en_q;
    scale_d  = scale_q;
    mirror_d = mirror_q;
    off_x_d  = off_x_q;
    off_y_d  = off_y_q;
    if (frame_start) begin
      en_d     = ctrl_fg_enable;
      scale_d  = ctrl_fg_scale;
      mirror_d = ctrl_fg_mirror_x;
      off_x_d  = fg_offset_x;
      off_y_d  = fg_offset_y;
    end

    win_w = RES_X_C >> scale_d;
    win_h = RES_Y_C >> scale_d;
    // One extra bit keeps offset + window size from wrapping.
    end_x = {1'b0, off_x_d} + {1'b0, win_w};
    end_y = {1'b0, off_y_d} + {1'b0, win_h};

    s1_valid_d  = in_valid;
    s1_dx_d     = pixel_x - off_x_d;
    s1_dy_d     = pixel_y - off_y_d;
    s1_in_win_d = (pixel_x >= off_x_d) && ({1'b0, pixel_x} < end_x) &&
                  (pixel_y >= off_y_d) && ({1'b0, pixel_y} < end_y);
    s1_en_d     = en_d;
    s1_scale_d  = scale_d;
    s1_mirror_d = mirror_d;
  end

  // Stage 2: mirror, upscale, and zero the coordinates outside the window.
  always_comb begin
    s2_win_w    = RES_X_C >> s1_scale_q;
    s2_src_x    = s1_mirror_q ? (s2_win_w - 1'b1 - s1_dx_q) : s1_dx_q;
    out_valid_d = s1_valid_q;
    fg_active_d = s1_valid_q && s1_en_q && s1_in_win_q;
    fg_x_d      = '0;
    fg_y_d      = '0;
    if (fg_active_d) begin
      fg_x_d = s2_src_x << s1_scale_q;
      fg_y_d = s1_dy_q << s1_scale_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      scale_q     <= '0;
      mirror_q    <= 1'b0;
      off_x_q     <= '0;
      off_y_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_dx_q     <= '0;
      s1_dy_q     <= '0;
      s1_in_win_q <= 1'b0;
      s1_en_q     <= 1'b0;
      s1_scale_q  <= '0;
      s1_mirror_q <= 1'b0;
      out_valid_q <= 1'b0;
      fg_active_q <= 1'b0;
      fg_x_q      <= '0;
      fg_y_q      <= '0;
    end else begin
      en_q        <= en_d;
      scale_q     <= scale_d;
      mirror_q    <= mirror_d;
      off_x_q     <= off_x_d;
      off_y_q     <= off_y_d;
      s1_valid_q  <= s1_valid_d;
      s1_dx_q     <= s1_dx_d;
      s1_dy_q     <= s1_dy_d;
      s1_in_win_q <= s1_in_win_d;
      s1_en_q     <= s1_en_d;
      s1_scale_q  <= s1_scale_d;
      s1_mirror_q <= s1_mirror_d;
      out_valid_q <= out_valid_d;
      fg_active_q <= fg_active_d;
      fg_x_q      <= fg_x_d;
      fg_y_q      <= fg_y_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign fg_active  = fg_active_q;
  assign fg_pixel_x = fg_x_q;
  assign fg_pixel_y = fg_y_q;

endmodule

// File: tb/tb_pipeline_foreground_transform.sv
// Directed bench for pipeline_foreground_transform with hand-computed expected coordinates.
module tb_pipeline_foreground_transform;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic       ctrl_fg_enable = 1'b0;
  logic [1:0] ctrl_fg_scale = '0;
  logic       ctrl_fg_mirror_x = 1'b0;
  logic [9:0] fg_offset_x = '0, fg_offset_y = '0;
  logic       out_valid, fg_active;
  logic [9:0] fg_pixel_x, fg_pixel_y;

  int checks = 0;
  int errors = 0;

  pipeline_foreground_transform dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .ctrl_fg_enable(ctrl_fg_enable), .ctrl_fg_scale(ctrl_fg_scale),
    .ctrl_fg_mirror_x(ctrl_fg_mirror_x), .fg_offset_x(fg_offset_x), .fg_offset_y(fg_offset_y),
    .out_valid(out_valid), .fg_pixel_x(fg_pixel_x), .fg_pixel_y(fg_pixel_y),
    .fg_active(fg_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input logic en, input logic [1:0] s, input logic mir,
                         input logic [9:0] ox, input logic [9:0] oy);
    ctrl_fg_enable   = en;
    ctrl_fg_scale    = s;
    ctrl_fg_mirror_x = mir;
    fg_offset_x      = ox;
    fg_offset_y      = oy;
  endtask

  // Drive one valid pixel, then blanking; check the result two clock edges later.
  task automatic pix(input string tag, input int x, input int y,
                     input int ex, input int ey, input logic eact);
    @(negedge clk);
    in_valid = 1'b1;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    @(negedge clk);
    in_valid = 1'b0;
    pixel_x  = 10'd5;
    pixel_y  = 10'd5;
    @(negedge clk);
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_act"}, 32'(fg_active), 32'(eact));
    check({tag, "_x"}, 32'(fg_pixel_x), 32'(ex));
    check({tag, "_y"}, 32'(fg_pixel_y), 32'(ey));
  endtask

  initial begin
    #1;
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_act", 32'(fg_active), 32'd0);
    check("rst_x", 32'(fg_pixel_x), 32'd0);
    check("rst_y", 32'(fg_pixel_y), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Before any frame start the layer is disabled even if the inputs say enabled.
    set_cfg(1'b1, 2'd0, 1'b0, 10'd0, 10'd0);
    pix("pre_frame", 123, 45, 0, 0, 1'b0);

    // 1: identity mapping
    pix("t1_fs", 0, 0, 0, 0, 1'b1);
    pix("t1", 123, 45, 123, 45, 1'b1);

    // 2: half scale, offset window
    set_cfg(1'b1, 2'd1, 1'b0, 10'd100, 10'd50);
    pix("t2_fs", 0, 0, 0, 0, 1'b0);
    pix("t2_tl", 100, 50, 0, 0, 1'b1);
    pix("t2_br", 419, 289, 638, 478, 1'b1);
    pix("t2_right", 420, 50, 0, 0, 1'b0);
    pix("t2_above", 150, 49, 0, 0, 1'b0);
    pix("t2_below", 150, 290, 0, 0, 1'b0);

    // 3: mirror
    set_cfg(1'b1, 2'd0, 1'b1, 10'd0, 10'd0);
    pix("t3_fs", 0, 0, 639, 0, 1'b1);
    pix("t3_l", 0, 10, 639, 10, 1'b1);
    pix("t3_r", 639, 10, 0, 10, 1'b1);
    set_cfg(1'b1, 2'd1, 1'b1, 10'd100, 10'd50);
    pix("t3_fs2", 0, 0, 0, 0, 1'b0);
    pix("t3_s1", 100, 50, 638, 0, 1'b1);

    // 4: clipped window and empty window
    set_cfg(1'b1, 2'd1, 1'b0, 10'd600, 10'd300);
    pix("t4_fs", 0, 0, 0, 0, 1'b0);
    pix("t4_clip", 639, 300, 78, 0, 1'b1);
    set_cfg(1'b1, 2'd1, 1'b0, 10'd1000, 10'd0);
    pix("t4_fs2", 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) pix("t4_empty", 600 + i * 13, 100 * i, 0, 0, 1'b0);

    // Max scale: window 80x60 at origin
    set_cfg(1'b1, 2'd3, 1'b0, 10'd0, 10'd0);
    pix("smax_fs", 0, 0, 0, 0, 1'b1);
    pix("smax_in", 79, 59, 632, 472, 1'b1);
    pix("smax_out", 80, 10, 0, 0, 1'b0);

    // 5: mid-frame changes are ignored until the next frame start
    set_cfg(1'b1, 2'd0, 1'b0, 10'd0, 10'd0);
    pix("t5_fs", 0, 0, 0, 0, 1'b1);
    set_cfg(1'b1, 2'd1, 1'b0, 10'd100, 10'd50);
    pix("t5_mid", 200, 100, 200, 100, 1'b1);
    pix("t5_fs2", 0, 0, 0, 0, 1'b0);
    pix("t5_new", 100, 50, 0, 0, 1'b1);
    set_cfg(1'b0, 2'd0, 1'b0, 10'd0, 10'd0);
    pix("t5_en_hold", 101, 51, 2, 2, 1'b1);

    // Blanking produces no output
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("blank_vld", 32'(out_valid), 32'd0);
    check("blank_act", 32'(fg_active), 32'd0);

    // 6: async reset mid-frame with pixels in flight
    set_cfg(1'b1, 2'd0, 1'b0, 10'd0, 10'd0);
    pix("t6_fs", 0, 0, 0, 0, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    pixel_x  = 10'd123;
    pixel_y  = 10'd45;
    @(negedge clk);
    pixel_x  = 10'd124;
    @(negedge clk);
    check("t6_pre_act", 32'(fg_active), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_vld", 32'(out_valid), 32'd0);
    check("t6_rst_act", 32'(fg_active), 32'd0);
    check("t6_rst_x", 32'(fg_pixel_x), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pix("t6_after", 123, 45, 0, 0, 1'b0);
    pix("t6_fs2", 0, 0, 0, 0, 1'b1);
    pix("t6_ok", 123, 45, 123, 45, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end

endmodule
